regfile_multiport: RTL
======================

// Module: regfile_multiport
// PURPOSE
//  General-purpose register file for the MIPS core, successor to the 1W/2R file.
//  Provides NUM_WR write ports, NUM_RD read ports, same-cycle write->read bypass and a register 0 that always reads zero.
//  Adds a per-register pending (scoreboard) bit so ID can detect operands still owed by in-flight loads/multicycle ops.
//  Sits between ID (read/mark) and WB (write/clear).
// PARAMETERS
//  DATA_W    32  register width in bits
//  NUM_REGS  32  number of architectural registers (power of 2, >=2)
//  ADDR_W    $clog2(NUM_REGS)  register address width (derived)
//  NUM_RD    2   number of read ports
//  NUM_WR    1   number of write ports
// PORTS
//  clk         in   1              clock, all state updates on rising edge
//  rst         in   1              asynchronous, active-low reset
//  we          in   NUM_WR         write enable per write port
//  waddr       in   NUM_WR*ADDR_W  write address, port i at [i*ADDR_W +: ADDR_W]
//  wdata       in   NUM_WR*DATA_W  write data, port i at [i*DATA_W +: DATA_W]
//  wclr        in   NUM_WR         with we[i]: also clear pending bit of waddr[i]
//  re          in   NUM_RD         read enable per read port
//  raddr       in   NUM_RD*ADDR_W  read address per port
//  rdata       out  NUM_RD*DATA_W  read data per port (combinational)
//  rpend       out  NUM_RD         operand of port j still pending (combinational)
//  mark_en     in   1              set pending bit of mark_addr (issue of long-latency producer)
//  mark_addr   in   ADDR_W         register to mark pending
//  pend_vec    out  NUM_REGS       current pending bits (registered), for debug/stall logic
// BEHAVIOUR
//  Reset (rst=0, async): all registers <= 0; all pending bits <= 0; pend_vec=0.
//   rdata/rpend are combinational: 0 while re=0.
//  Write: on clk rising, for each i with we[i]=1 and waddr[i]!=0: reg[waddr[i]] <= wdata[i].
//   Writes to address 0 are discarded; reg 0 is never stored and never pending.
//  Write conflict: several ports with we=1 to same address -> highest port index wins (data and wclr).
//  Read port j, zero latency:
//   - re[j]=0 -> rdata=0, rpend=0
//   - raddr=0 -> rdata=0, rpend=0
//   - else if any we[i] && waddr[i]==raddr[j] -> rdata = wdata of highest such i (bypass); rpend=0 when that port's wclr=1
//   - else rdata = reg[raddr[j]], rpend = pending[raddr[j]]
//  Pending bit update (per register r!=0), on clk rising:
//   - set when mark_en && mark_addr==r
//   - cleared when some we[i]&&wclr[i]&&waddr[i]==r
//   - set and clear same cycle -> set wins (newer producer issued)
//   - mark_addr==0 ignored
//  Bypass of rpend: when a clear targets raddr[j] in the same cycle, rpend=0.
//   A same-cycle mark does not raise rpend; it takes effect next cycle.
//  Writes with wclr=0 update data only; the pending bit is unchanged.
//  Reset mid-operation: state clears immediately. The first edge after rst deasserts acts on inputs normally.
//  No X propagation: out-of-range ports are impossible by width. All outputs are defined from reset.
// TESTING
//  1 Reset: rst=0 with we=1 -> after release, read r1..r31 = 0, pend_vec=0.
//  2 Basic/zero: write r5=0xDEADBEEF, write r0=0x1234 -> next cycle port0 r5=0xDEADBEEF, port1 r0=0.
//  3 Bypass: same cycle we r7=0xA5A5A5A5, raddr0=7 -> rdata0=0xA5A5A5A5 in that cycle, not old value.
//  4 Conflict (NUM_WR=2): port0 r3=0x11, port1 r3=0x22 same cycle -> r3 reads 0x22 next cycle and in bypass.
//  5 Scoreboard: mark r9; next cycle rpend=1 for r9; WB we+wclr r9=0x55 -> same cycle rpend=0, rdata=0x55; pend_vec[9]=0 next cycle.
//  6 Set/clear race: mark r4 and we+wclr r4 same cycle -> pend_vec[4]=1 next cycle. Mark r0 -> pend_vec stays 0.

Source files
------------

// File: rtl/regfile_multiport.sv
// regfile_multiport
//   General-purpose register file for the MIPS core. It has NUM_WR write ports,
//   NUM_RD zero-latency read ports and same-cycle write->read bypass.
//   Register 0 always reads as zero.
//   Each register has a pending (scoreboard) bit. ID sets the bit when it issues
//   a long-latency producer. WB clears the bit when it writes the result back.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        asynchronous, active-low reset
//   we         per-write-port enable
//   waddr      write addresses, port i at [i*ADDR_W +: ADDR_W]
//   wdata      write data, port i at [i*DATA_W +: DATA_W]
//   wclr       per-write-port: also clear the pending bit of waddr[i]
//   re         per-read-port enable
//   raddr      read addresses, port j at [j*ADDR_W +: ADDR_W]
//   rdata      read data (combinational), port j at [j*DATA_W +: DATA_W]
//   rpend      operand of read port j is still pending (combinational)
//   mark_en    set the pending bit of mark_addr
//   mark_addr  register to mark pending
//   pend_vec   registered pending bits for all registers
module regfile_multiport #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR*ADDR_W-1:0]   waddr,
  input  logic [NUM_WR*DATA_W-1:0]   wdata,
  input  logic [NUM_WR-1:0]          wclr,
  input  logic [NUM_RD-1:0]          re,
  input  logic [NUM_RD*ADDR_W-1:0]   raddr,
  output logic [NUM_RD*DATA_W-1:0]   rdata,
  output logic [NUM_RD-1:0]          rpend,
  input  logic                       mark_en,
  input  logic [ADDR_W-1:0]          mark_addr,
  output logic [NUM_REGS-1:0]        pend_vec
);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] pend_reg;
  logic [NUM_REGS-1:0] pend_next;

  // Resolved write for each register this cycle. The port with the highest
  // index that targets a register wins. Its data and its wclr are both used.
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] wr_clr;
  logic [DATA_W-1:0]   wr_data [NUM_REGS];

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      wr_hit[r]  = 1'b0;
      wr_clr[r]  = 1'b0;
      wr_data[r] = '0;
    end
    // Ascending scan: a later (higher) port overwrites an earlier one.
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i]) begin
        wr_hit[waddr[i*ADDR_W +: ADDR_W]]  = 1'b1;
        wr_clr[waddr[i*ADDR_W +: ADDR_W]]  = wclr[i];
        wr_data[waddr[i*ADDR_W +: ADDR_W]] = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A mark is applied after the clear. If both hit the same register, the
  // bit ends up set, because the newer producer was issued this cycle.
  always_comb begin
    pend_next = pend_reg & ~wr_clr;
    if (mark_en) begin
      pend_next[mark_addr] = 1'b1;
    end
    pend_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= '0;
      end
      pend_reg <= '0;
    end else begin
      // Register 0 is never written, so it keeps its reset value of zero.
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_reg[r] <= wr_data[r];
        end
      end
      pend_reg <= pend_next;
    end
  end

  assign pend_vec = pend_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic [DATA_W-1:0] rd;
      logic              rp;

      assign ra = raddr[gi*ADDR_W +: ADDR_W];

      // A same-cycle write bypasses the stored value. Its wclr also hides the
      // pending bit at once. A same-cycle mark is seen only on the next cycle.
      always_comb begin
        rd = '0;
        rp = 1'b0;
        if (re[gi] && (ra != '0)) begin
          if (wr_hit[ra]) begin
            rd = wr_data[ra];
            rp = wr_clr[ra] ? 1'b0 : pend_reg[ra];
          end else begin
            rd = regs_reg[ra];
            rp = pend_reg[ra];
          end
        end
      end

      assign rdata[gi*DATA_W +: DATA_W] = rd;
      assign rpend[gi]                  = rp;
    end
  endgenerate

endmodule
